load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator-side controller that drives one port of the core's dual-port word memory (4096 x 32, 1-cycle registered read, write-first, word-granular write enable) on behalf of the execute stage.
- Accepts byte-addressed RISC-V loads and stores of byte, halfword and word size over a valid/ready request channel. Returns results over a valid/ready response channel.
- Translates byte addresses to word indices, sign- or zero-extends load data, performs read-modify-write for sub-word stores, and flags misaligned, illegal-size or out-of-range accesses without touching memory.

Parameters:
- ADDR_WIDTH, 12, word-index width. Memory depth is 2^ADDR_WIDTH words; byte addresses at or above 2^(ADDR_WIDTH+2) fault.

Ports:
- clk  input  1  single clock; every register is on posedge clk.
- rst  input  1  synchronous active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  high only in IDLE.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  response present; held until accepted.
- resp_ready  input  1  consumer accepts the response.
- resp_rdata  output  32  extended load data; 0 for stores and faults.
- resp_fault  output  1  access rejected.
- mem_write_enable  output  1  memory port write enable.
- mem_access_address  output  32  word index, {(32-ADDR_WIDTH) zeros, index}.
- mem_write_data  output  32  memory port write data.
- mem_read_data  input  32  memory port registered read data.

Behaviour:
- States: IDLE, ACCESS, CAPTURE, WRITE, RESP. All outputs are registered or decoded from state only; there is no combinational path from any input to any output.
- Reset: state=IDLE, resp_valid=0, resp_rdata=0, resp_fault=0, mem_write_enable=0, mem_access_address=0, mem_write_data=0.
- IDLE: req_ready=1. On req_valid, latch the request.
  - Fault if any of these hold: size=11; half with addr[0]=1; word with addr[1:0]!=0; addr[31:ADDR_WIDTH+2]!=0. On fault: go to RESP with resp_fault=1 and resp_rdata=0. No memory cycle is issued.
  - Otherwise go to ACCESS, driving the word index addr[ADDR_WIDTH+1:2].
- ACCESS (1 cycle):
  - Word store: mem_write_enable=1, mem_write_data=wdata, then go to RESP.
  - Load or sub-word store: mem_write_enable=0 (read), then go to CAPTURE.
- CAPTURE (1 cycle): mem_read_data is valid.
  - Load: select the lane, little-endian. Byte lane = addr[1:0]; half lane = addr[1]. Extend per req_unsigned, register into resp_rdata, then go to RESP.
  - Sub-word store: merge wdata[7:0] or wdata[15:0] into the selected lane of the read word. Register the result into mem_write_data, then go to WRITE.
- WRITE (1 cycle): mem_write_enable=1 with the merged data, then go to RESP.
- RESP: resp_valid=1 with resp_rdata and resp_fault stable. When resp_ready is high, clear resp_valid and go to IDLE. There is no back-to-back acceptance: the earliest next req_ready is the cycle after the handshake.
- Latency (request-accept edge to first resp_valid cycle): fault 1, word store 2, load 3, sub-word store 4.
- mem_write_enable is 1 only in ACCESS (word store) and WRITE. mem_access_address and mem_write_data hold their last values otherwise.
- req_* inputs outside IDLE are ignored. resp_ready outside RESP is ignored.
- Reset mid-operation returns to IDLE with no response.
  - A write whose mem_write_enable is high in the reset cycle still commits, because the memory has no reset.
  - A sub-word store reset in ACCESS or CAPTURE leaves memory unchanged.

Optional Feature:
- Macro LSU_PERF_EN.
- Defined: adds outputs perf_loads, perf_stores and perf_faults, each 32 bits. Each counter increments by 1 at the response handshake of a successful load, a successful store, or a fault respectively. Counters wrap 0xFFFFFFFF -> 0 and clear on rst.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Preload word 4 = 0x8081F2F3. Byte load, addr 0x10, signed -> resp_rdata=0xFFFFFFF3, resp_valid 3 cycles after accept. Byte load, addr 0x13, unsigned -> 0x00000080.
- Half load, addr 0x12, signed, same word -> 0xFFFF8081. Half load, addr 0x11 -> resp_fault=1, resp_rdata=0, no mem_write_enable, resp_valid 1 cycle after accept.
- Word store 0xDEADBEEF to addr 0x20 -> one mem_write_enable pulse, address 8, resp_valid 2 cycles after accept. Subsequent word load from 0x20 returns 0xDEADBEEF.
- Word 8 = 0xDEADBEEF; byte store wdata 0x000000AA to addr 0x21 -> one read then one write, word 8 = 0xDEADAAEF, resp_valid 4 cycles after accept. Half store 0x1234 to addr 0x22 -> word 8 = 0x1234AAEF.
- Word load from 0x4000 (ADDR_WIDTH=12) -> fault. Size 11 -> fault. Hold resp_ready low for 5 cycles -> resp_valid and data stable, req_ready=0 throughout.
- Assert rst in the CAPTURE cycle of a byte store -> memory unchanged, state IDLE, no resp_valid. With LSU_PERF_EN, after the above sequence the counters match the counts of successful loads, successful stores and faults.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte-addressed RISC-V load/store controller for a 1-cycle registered-read word memory
// Optional feature macro: LSU_PERF_EN adds perf_loads, perf_stores and perf_faults counters.
module load_store_unit #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_write_enable,
  output logic [31:0] mem_access_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
`ifdef LSU_PERF_EN
  ,
  output logic [31:0] perf_loads,
  output logic [31:0] perf_stores,
  output logic [31:0] perf_faults
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_CAPTURE, S_WRITE, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata;
  logic        w_fault;
  logic        w_word_store;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_merge;

  assign req_ready        = (r_state == S_IDLE);
  assign resp_valid       = (r_state == S_RESP);
  assign w_word_store     = r_write && (r_size == 2'b10);
  // Word stores write straight from ACCESS; sub-word stores write after the merge.
  assign mem_write_enable = ((r_state == S_ACCESS) && w_word_store) || (r_state == S_WRITE);

  // Reject illegal size, misalignment and addresses beyond the memory before any memory cycle.
  always_comb begin
    w_fault = 1'b0;
    if (req_size == 2'b11) w_fault = 1'b1;
    if ((req_size == 2'b01) && req_addr[0]) w_fault = 1'b1;
    if ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) w_fault = 1'b1;
    if ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0) w_fault = 1'b1;
  end

  // Little-endian lane extraction and extension of the read word for loads.
  always_comb begin
    w_byte = 8'h00;
    case (r_lane)
      2'd0: w_byte = mem_read_data[7:0];
      2'd1: w_byte = mem_read_data[15:8];
      2'd2: w_byte = mem_read_data[23:16];
      default: w_byte = mem_read_data[31:24];
    endcase
    w_half = r_lane[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    case (r_size)
      2'b00:   w_load_data = {{24{~r_unsigned & w_byte[7]}}, w_byte};
      2'b01:   w_load_data = {{16{~r_unsigned & w_half[15]}}, w_half};
      default: w_load_data = mem_read_data;
    endcase
  end

  // Merge store data into the selected lane of the read word for sub-word stores.
  always_comb begin
    w_merge = mem_read_data;
    if (r_size == 2'b00) begin
      case (r_lane)
        2'd0: w_merge = {mem_read_data[31:8], r_wdata[7:0]};
        2'd1: w_merge = {mem_read_data[31:16], r_wdata[7:0], mem_read_data[7:0]};
        2'd2: w_merge = {mem_read_data[31:24], r_wdata[7:0], mem_read_data[15:0]};
        default: w_merge = {r_wdata[7:0], mem_read_data[23:0]};
      endcase
    end else if (r_size == 2'b01) begin
      w_merge = r_lane[1] ? {r_wdata, mem_read_data[15:0]} : {mem_read_data[31:16], r_wdata};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode; the response waits in RESP until the consumer accepts it.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (req_valid) w_next = w_fault ? S_RESP : S_ACCESS;
      S_ACCESS:  w_next = w_word_store ? S_RESP : S_CAPTURE;
      S_CAPTURE: w_next = r_write ? S_WRITE : S_RESP;
      S_WRITE:   w_next = S_RESP;
      S_RESP:    if (resp_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Request latch, memory port drive and response data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_write            <= 1'b0;
      r_size             <= 2'b00;
      r_unsigned         <= 1'b0;
      r_lane             <= 2'b00;
      r_wdata            <= 16'h0000;
      resp_rdata         <= 32'h0;
      resp_fault         <= 1'b0;
      mem_access_address <= 32'h0;
      mem_write_data     <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write    <= req_write;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_lane     <= req_addr[1:0];
            r_wdata    <= req_wdata[15:0];
            resp_rdata <= 32'h0;
            resp_fault <= w_fault;
            if (!w_fault) begin
              mem_access_address <= {{(32 - ADDR_WIDTH){1'b0}}, req_addr[ADDR_WIDTH+1:2]};
              if (req_write && (req_size == 2'b10)) mem_write_data <= req_wdata;
            end
          end
        end
        S_CAPTURE: begin
          if (r_write) mem_write_data <= w_merge;
          else         resp_rdata     <= w_load_data;
        end
        default: ;
      endcase
    end
  end

`ifdef LSU_PERF_EN
  // Event counters bumped at the response handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_loads  <= 32'h0;
      perf_stores <= 32'h0;
      perf_faults <= 32'h0;
    end else if ((r_state == S_RESP) && resp_ready) begin
      if (resp_fault)   perf_faults <= perf_faults + 32'd1;
      else if (r_write) perf_stores <= perf_stores + 32'd1;
      else              perf_loads  <= perf_loads + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a behavioural memory model
module tb_load_store_unit;
  localparam int AW     = 12;
  localparam int NWORDS = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_write_enable;
  logic [31:0] mem_access_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
`ifdef LSU_PERF_EN
  logic [31:0] perf_loads;
  logic [31:0] perf_stores;
  logic [31:0] perf_faults;
`endif

  load_store_unit #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault),
    .mem_write_enable(mem_write_enable), .mem_access_address(mem_access_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
`ifdef LSU_PERF_EN
    , .perf_loads(perf_loads), .perf_stores(perf_stores), .perf_faults(perf_faults)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          acc_cyc;
    int          lat;
    int          writes;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          wr_count = 0;
  int          wr_exp = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  int          n_loads = 0;
  int          n_stores = 0;
  int          n_faults = 0;
  int          hold_next = -1;
  logic [31:0] ref_mem [NWORDS];
  logic [31:0] tb_mem [4096];
  logic        pl_en = 1'b0;
  logic [11:0] pl_idx = 12'h0;
  logic [31:0] pl_data = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  // Word memory: 1-cycle registered read, write-first, no reset.
  always @(posedge clk) begin
    if (pl_en) begin
      tb_mem[pl_idx] <= pl_data;
    end else if (mem_write_enable) begin
      tb_mem[mem_access_address[11:0]] <= mem_write_data;
      wr_count <= wr_count + 1;
    end
    mem_read_data <= mem_write_enable ? mem_write_data : tb_mem[mem_access_address[11:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, req);
    end
  endtask

  // Reference model computes the response at issue time, then drives the request until accepted.
  task automatic issue(input logic w, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                       input logic [31:0] wd, input bit use_c, input logic [31:0] c_rdata);
    exp_t        e;
    int          widx;
    int          off;
    int          waited;
    logic [31:0] word;
    logic [31:0] v;
    logic [31:0] mask;
    logic        f;
    f = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) ||
        (a >= (32'd1 << (AW + 2)));
    widx = int'(a >> 2);
    off  = int'(a[1:0]);
    e.rdata = 32'h0;
    e.fault = f;
    e.lat   = 1;
    if (f) begin
      n_faults++;
    end else if (w) begin
      n_stores++;
      wr_exp++;
      if (sz == 2'b10) begin
        ref_mem[widx] = wd;
        e.lat = 2;
      end else begin
        mask = ((sz == 2'b00) ? 32'hFF : 32'hFFFF) << (8 * off);
        ref_mem[widx] = (ref_mem[widx] & ~mask) | ((wd << (8 * off)) & mask);
        e.lat = 4;
      end
    end else begin
      n_loads++;
      e.lat = 3;
      word = ref_mem[widx] >> (8 * off);
      if (sz == 2'b00) begin
        v = word & 32'hFF;
        if (!uns && v >= 32'h80) v = v - 32'h100;
      end else if (sz == 2'b01) begin
        v = word & 32'hFFFF;
        if (!uns && v >= 32'h8000) v = v - 32'h10000;
      end else begin
        v = word;
      end
      e.rdata = v;
    end
    if (use_c) e.rdata = c_rdata;
    e.writes = wr_exp;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    waited = 0;
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      n_vec++; n_bad++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1");
      req_valid = 1'b0;
      return;
    end
    e.acc_cyc = cyc;
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    while ((exp_q.size() != 0 || !req_ready) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    n_vec++;
    if (exp_q.size() != 0 || !req_ready) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  // Monitor: pops the scoreboard when a response appears and checks it while it is held.
  initial begin : monitor
    exp_t        e;
    bit          in_resp;
    int          wait_left;
    logic [31:0] held_rdata;
    logic [31:0] rr;
    in_resp = 0;
    wait_left = 0;
    held_rdata = 32'h0;
    forever begin
      @(negedge clk);
      rr = $urandom;
      if (rst) begin
        in_resp = 0;
        resp_ready = 1'b0;
      end else if (resp_valid) begin
        if (!in_resp) begin
          in_resp = 1;
          wait_left = (hold_next >= 0) ? hold_next : int'(rr[1:0] % 3);
          hold_next = -1;
          if (exp_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL unexpected_resp: got resp_valid=1 expected 0");
          end else begin
            e = exp_q.pop_front();
            check("latency", cyc - e.acc_cyc, e.lat);
            check("resp_rdata", resp_rdata, e.rdata);
            check("resp_fault", {31'b0, resp_fault}, {31'b0, e.fault});
            check("mem_writes", wr_count, e.writes);
          end
          held_rdata = resp_rdata;
        end else begin
          check("held_rdata", resp_rdata, held_rdata);
        end
        check("ready_in_resp", {31'b0, req_ready}, 32'd0);
        if (wait_left == 0) begin
          resp_ready = 1'b1;
        end else begin
          resp_ready = 1'b0;
          wait_left--;
        end
      end else begin
        in_resp = 0;
        resp_ready = rr[2];
      end
    end
  end

  initial begin : stimulus
    logic [31:0] a;
    logic [31:0] r;
    for (int i = 0; i < NWORDS; i++) begin
      @(negedge clk);
      pl_en = 1'b1;
      pl_idx = i[11:0];
      pl_data = (i == 4) ? 32'h8081F2F3 : $urandom;
      ref_mem[i] = pl_data;
    end
    @(negedge clk);
    pl_en = 1'b0;
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_we", {31'b0, mem_write_enable}, 32'd0);
    check("rst_addr", mem_access_address, 32'h0);
    check("rst_wdata", mem_write_data, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_fault", {31'b0, resp_fault}, 32'd0);
    rst = 1'b0;

    issue(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1, 32'hFFFFFFF3);
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1, 32'h00000080);
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1, 32'hFFFF8081);
    issue(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 1, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 1, 32'h0);
    check("wstore_addr", mem_access_address, 32'd8);
    check("wstore_we", {31'b0, mem_write_enable}, 32'd1);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1, 32'hDEADBEEF);
    issue(1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA, 1, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1, 32'hDEADAAEF);
    issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h00001234, 1, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1, 32'h1234AAEF);
    issue(1'b0, 2'b10, 1'b0, 32'h4000, 32'h0, 1, 32'h0);
    wait_idle();
    hold_next = 5;
    issue(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1, 32'h0);

    for (int t = 0; t < 250; t++) begin
      r = $urandom;
      a = 32'($urandom_range(0, 4 * NWORDS - 1));
      if (r[7:5] == 3'd0) a = r[8] ? (32'h4000 + {26'b0, r[14:9]}) : $urandom;
      issue(r[0], r[2:1], r[3], a, $urandom, 0, 32'h0);
    end
    wait_idle();

    for (int i = 0; i < NWORDS; i++) check("mem_contents", tb_mem[i], ref_mem[i]);
`ifdef LSU_PERF_EN
    check("perf_loads", perf_loads, n_loads);
    check("perf_stores", perf_stores, n_stores);
    check("perf_faults", perf_faults, n_faults);
`endif

    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h25; req_wdata = 32'h00000055;
    check("rst_test_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", {31'b0, req_ready}, 32'd1);
    check("midrst_we", {31'b0, mem_write_enable}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      check("midrst_no_resp", {31'b0, resp_valid}, 32'd0);
      @(negedge clk);
    end
    check("midrst_mem", tb_mem[9], ref_mem[9]);
`ifdef LSU_PERF_EN
    check("perf_loads_clr", perf_loads, 32'd0);
    check("perf_stores_clr", perf_stores, 32'd0);
    check("perf_faults_clr", perf_faults, 32'd0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
